// File: rtl/mem_map_pkg.sv
// Shared types and decode helpers for the data-port memory-map controller.
package mem_map_pkg;

  typedef enum logic [1:0] {
    RGN_DMEM,
    RGN_IMEM,
    RGN_IO,
    RGN_UNMAPPED
  } region_e;

  typedef enum logic [1:0] {
    SEL_DMEM = 2'b00,
    SEL_IO   = 2'b01,
    SEL_ZERO = 2'b10
  } sel_e;

  localparam logic [1:0] FLT_NONE       = 2'b00;
  localparam logic [1:0] FLT_UNMAPPED   = 2'b01;
  localparam logic [1:0] FLT_IMEM_LD    = 2'b10;
  localparam logic [1:0] FLT_IO_TIMEOUT = 2'b11;

  // Overlapping patterns: earlier entries take priority.
  function automatic region_e region_of(input logic [3:0] top4);
    casez (top4)
      4'b0??1: return RGN_DMEM;
      4'b0?1?: return RGN_IMEM;
      4'b1000: return RGN_IO;
      default: return RGN_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// Shift register of {valid, sel} that delays a load-source select to line up
// with the DMEM read latency.
module lat_pipe
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  input  sel_e push_sel,
  output logic pop_valid,
  output sel_e pop_sel
);

  logic [DEPTH-1:0] vld_q;
  sel_e             sel_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) sel_q[i] <= SEL_ZERO;
    end else begin
      vld_q[0] <= push_valid;
      sel_q[0] <= push_sel;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  assign pop_valid = vld_q[DEPTH-1];
  assign pop_sel   = sel_q[DEPTH-1];

endmodule

// File: rtl/mem_map_ctrl.sv
// Data-port memory-map controller: region decode, store-mask gating, IO
// handshake with timeout, latency-aligned load mux and sticky fault capture.
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_store_mask,
  input  logic              req_load,
  output logic [3:0]        store_mask_dmem,
  output logic [3:0]        store_mask_imem,
  output logic              io_valid,
  output logic [ADDR_W-1:0] io_addr,
  output logic [3:0]        io_store_mask,
  input  logic              io_ready,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clr
);

  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StIoWait} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               io_load_q;
  logic [DATA_W-1:0]  io_rdata_q;

  region_e            rgn;
  logic               is_store, is_load, idle, access, io_req, io_done, io_tmo;
  logic               push_valid, pop_valid;
  sel_e               push_sel, pop_sel;
  logic               flt_valid;
  logic [1:0]         flt_code;
  logic [ADDR_W-1:0]  flt_addr;

  always_comb begin
    rgn      = region_of(req_addr[ADDR_W-1 -: 4]);
    is_store = |req_store_mask;
    is_load  = req_load & ~is_store;
    idle     = (state_q == StIdle);
    // New requests are only looked at while no IO access is outstanding.
    access   = idle & req_valid & (is_store | req_load);
    io_req   = access & (rgn == RGN_IO);
    io_done  = ~idle & io_ready;
    io_tmo   = ~idle & ~io_ready & (cnt_q == CNT_W'(IO_TIMEOUT - 1));
    stall    = io_req | (~idle & ~io_done & ~io_tmo);

    store_mask_dmem = (access && rgn == RGN_DMEM) ? req_store_mask : 4'b0000;
    store_mask_imem = (access && rgn == RGN_IMEM) ? req_store_mask : 4'b0000;

    push_valid = 1'b0;
    push_sel   = SEL_ZERO;
    flt_valid  = 1'b0;
    flt_code   = FLT_NONE;
    flt_addr   = req_addr;
    if (access) begin
      unique case (rgn)
        RGN_DMEM: if (is_load) begin
          push_valid = 1'b1;
          push_sel   = SEL_DMEM;
        end
        RGN_IMEM: if (is_load) begin
          push_valid = 1'b1;
          flt_valid  = 1'b1;
          flt_code   = FLT_IMEM_LD;
        end
        RGN_IO: ;
        RGN_UNMAPPED: begin
          push_valid = is_load;
          flt_valid  = 1'b1;
          flt_code   = FLT_UNMAPPED;
        end
      endcase
    end
    if (io_done && io_load_q) begin
      push_valid = 1'b1;
      push_sel   = SEL_IO;
    end
    if (io_tmo) begin
      push_valid = io_load_q;
      flt_valid  = 1'b1;
      flt_code   = FLT_IO_TIMEOUT;
      flt_addr   = io_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      io_load_q     <= 1'b0;
      io_valid      <= 1'b0;
      io_addr       <= '0;
      io_store_mask <= '0;
      io_rdata_q    <= '0;
      fault         <= 1'b0;
      fault_code    <= FLT_NONE;
      fault_addr    <= '0;
    end else begin
      case (state_q)
        StIdle: if (io_req) begin
          io_valid      <= 1'b1;
          io_addr       <= req_addr;
          io_store_mask <= req_store_mask;
          io_load_q     <= is_load;
          cnt_q         <= '0;
          state_q       <= StIoWait;
        end
        StIoWait: begin
          if (cnt_q != CNT_W'(IO_TIMEOUT)) cnt_q <= cnt_q + CNT_W'(1);
          if (io_done) io_rdata_q <= io_rdata;
          if (io_done || io_tmo) begin
            io_valid <= 1'b0;
            state_q  <= StIdle;
          end
        end
      endcase

      // A clear in the same cycle as a new fault lets the new fault in.
      if (flt_valid && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= flt_code;
        fault_addr <= flt_addr;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FLT_NONE;
        fault_addr <= '0;
      end
    end
  end

  lat_pipe #(
    .DEPTH(RD_LAT)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(push_valid),
    .push_sel  (push_sel),
    .pop_valid (pop_valid),
    .pop_sel   (pop_sel)
  );

  always_comb begin
    load_valid = pop_valid;
    load_data  = '0;
    if (pop_valid) begin
      case (pop_sel)
        SEL_DMEM: load_data = dmem_rdata;
        SEL_IO:   load_data = io_rdata_q;
        default:  load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Scoreboard bench for mem_map_ctrl: a driver issues accesses and queues the
// expected load results; a monitor pops them when load_valid is seen.
module tb_mem_map_ctrl;

  localparam int RD_LAT = 2;
  localparam int IO_TO  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_load, io_ready, fault_clr;
  logic [31:0] req_addr, io_rdata, dmem_rdata;
  logic [3:0]  req_store_mask;
  logic [3:0]  store_mask_dmem, store_mask_imem, io_store_mask;
  logic        io_valid, load_valid, stall, fault;
  logic [31:0] io_addr, load_data, fault_addr;
  logic [1:0]  fault_code;

  mem_map_ctrl #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .RD_LAT    (RD_LAT),
    .IO_TIMEOUT(IO_TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_store_mask (req_store_mask),
    .req_load       (req_load),
    .store_mask_dmem(store_mask_dmem),
    .store_mask_imem(store_mask_imem),
    .io_valid       (io_valid),
    .io_addr        (io_addr),
    .io_store_mask  (io_store_mask),
    .io_ready       (io_ready),
    .io_rdata       (io_rdata),
    .dmem_rdata     (dmem_rdata),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .stall          (stall),
    .fault          (fault),
    .fault_code     (fault_code),
    .fault_addr     (fault_addr),
    .fault_clr      (fault_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DMEM returns a cycle-dependent word so the expected value pins the latency.
  function automatic logic [31:0] hash(input int c);
    return (c * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  assign dmem_rdata = hash(cyc);

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].c != cyc) begin
        check("unexpected_load_valid", 32'(load_valid), 32'd0);
      end else begin
        check("load_data", load_data, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
      check("missing_load_valid", 32'(load_valid), 32'd1);
      void'(exp_q.pop_front());
    end
  end

  // Reference fault state as seen after the most recent clock edge.
  logic        m_fault = 1'b0;
  logic [1:0]  m_code  = 2'b00;
  logic [31:0] m_addr  = 32'h0;

  task automatic check_fault();
    check("fault", 32'(fault), 32'(m_fault));
    if (m_fault) begin
      check("fault_code", 32'(fault_code), 32'(m_code));
      check("fault_addr", fault_addr, m_addr);
    end
  endtask

  task automatic fault_update(input logic ev, input logic [1:0] code, input logic [31:0] a,
                              input logic clr);
    if (ev && (!m_fault || clr)) begin
      m_fault = 1'b1;
      m_code  = code;
      m_addr  = a;
    end else if (clr) begin
      m_fault = 1'b0;
    end
  endtask

  // 0 DMEM, 1 IMEM, 2 IO, 3 unmapped.
  function automatic int region(input logic [31:0] a);
    int t;
    t = int'(a >> 28);
    if (t < 8 && t % 2 == 1) return 0;
    if (t < 8 && (t / 2) % 2 == 1) return 1;
    if (t == 8) return 2;
    return 3;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 0; req_load = 0; req_store_mask = 0; fault_clr = 0; io_ready = 0;
      @(negedge clk);
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_mask_dmem", 32'(store_mask_dmem), 32'd0);
      check_fault();
      next_cycle();
    end
  endtask

  task automatic do_access(input logic [31:0] addr, input logic [3:0] mask, input logic ld,
                           input int wait_n, input logic [31:0] io_d, input logic clr);
    int   rg;
    logic acc, ldo, ev;
    logic [1:0] code;
    exp_t e;
    rg  = region(addr);
    acc = (mask != 0) || ld;
    ldo = ld && (mask == 0);
    req_valid = 1; req_addr = addr; req_store_mask = mask; req_load = ld;
    fault_clr = clr; io_ready = 0;
    @(negedge clk);
    check("mask_dmem", 32'(store_mask_dmem), (acc && rg == 0) ? 32'(mask) : 32'd0);
    check("mask_imem", 32'(store_mask_imem), (acc && rg == 1) ? 32'(mask) : 32'd0);
    check("stall_req", 32'(stall), 32'(acc && rg == 2));
    check("io_valid_idle", 32'(io_valid), 32'd0);
    check_fault();
    ev = 0; code = 2'b00;
    if (acc && rg == 0 && ldo) begin
      e.c = cyc + RD_LAT; e.d = hash(cyc + RD_LAT); exp_q.push_back(e);
    end else if (acc && rg == 1 && ldo) begin
      ev = 1; code = 2'b10;
      e.c = cyc + RD_LAT; e.d = 0; exp_q.push_back(e);
    end else if (acc && rg == 3) begin
      ev = 1; code = 2'b01;
      if (ldo) begin
        e.c = cyc + RD_LAT; e.d = 0; exp_q.push_back(e);
      end
    end
    fault_update(ev, code, addr, clr);
    next_cycle();
    if (acc && rg == 2) begin
      for (int k = 1; k <= IO_TO; k++) begin
        // A DMEM store shown while stalled must not reach the DMEM mask.
        req_addr = 32'h1000_0000 | 32'($urandom_range(0, 255));
        req_store_mask = 4'hF; req_load = 0; fault_clr = 0;
        io_ready = (k == wait_n);
        io_rdata = (k == wait_n) ? io_d : $urandom;
        @(negedge clk);
        check("io_valid", 32'(io_valid), 32'd1);
        check("io_addr", io_addr, addr);
        check("io_store_mask", 32'(io_store_mask), 32'(mask));
        check("wait_mask_dmem", 32'(store_mask_dmem), 32'd0);
        check("stall_wait", 32'(stall), 32'(!(k == wait_n || k == IO_TO)));
        check_fault();
        ev = 0;
        if (k == wait_n) begin
          if (ldo) begin
            e.c = cyc + RD_LAT; e.d = io_d; exp_q.push_back(e);
          end
        end else if (k == IO_TO) begin
          ev = 1;
          if (ldo) begin
            e.c = cyc + RD_LAT; e.d = 0; exp_q.push_back(e);
          end
        end
        fault_update(ev, 2'b11, addr, 1'b0);
        next_cycle();
        if (k == wait_n) break;
      end
      io_ready = 0;
    end
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_addr = 0; req_store_mask = 0; req_load = 0;
    io_ready = 0; io_rdata = 0; fault_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_io_valid", 32'(io_valid), 32'd0);
    check("rst_io_addr", io_addr, 32'd0);
    check("rst_io_mask", 32'(io_store_mask), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    next_cycle();
    rst_n = 1;
    idle_cycles(2);

    do_access(32'h1000_0000, 4'b0011, 0, 0, 0, 0);
    do_access(32'h1000_0004, 4'b0000, 1, 0, 0, 0);
    do_access(32'h3000_0000, 4'b1111, 0, 0, 0, 0);
    do_access(32'h2000_0000, 4'b1111, 0, 0, 0, 0);
    do_access(32'h2000_0000, 4'b0000, 1, 0, 0, 0);
    do_access(32'h1000_0008, 4'b0001, 1, 0, 0, 1);
    do_access(32'h8000_0010, 4'b0000, 1, 3, 32'h0000_00A5, 0);
    idle_cycles(RD_LAT + 1);
    do_access(32'h8000_0010, 4'b0000, 1, IO_TO + 1, 0, 0);
    idle_cycles(RD_LAT + 1);
    do_access(32'h1000_0000, 4'b0001, 0, 0, 0, 1);
    do_access(32'h9000_0000, 4'b0001, 0, 0, 0, 0);
    do_access(32'hF000_0000, 4'b0001, 1, 0, 0, 0);
    do_access(32'hA000_0000, 4'b0000, 1, 0, 0, 1);
    do_access(32'h8000_0020, 4'b1100, 0, 2, 32'h1234_5678, 0);
    idle_cycles(RD_LAT + 1);

    // Reset in the middle of an IO wait abandons the access and the fault.
    req_valid = 1; req_addr = 32'h8000_0040; req_store_mask = 0; req_load = 1;
    @(negedge clk);
    check("rstmid_stall_req", 32'(stall), 32'd1);
    next_cycle();
    req_valid = 0; req_load = 0; rst_n = 0;
    @(negedge clk);
    check("rstmid_stall_wait", 32'(stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("rstmid_io_valid", 32'(io_valid), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_load_valid", 32'(load_valid), 32'd0);
    check("rstmid_fault", 32'(fault), 32'd0);
    m_fault = 0;
    next_cycle();
    rst_n = 1;
    idle_cycles(RD_LAT + 2);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [3:0]  m;
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      if (i % 5 == 0) a[31:28] = 4'h8;
      m = ($urandom % 2 == 1) ? 4'($urandom) : 4'h0;
      do_access(a, m, 1'($urandom), $urandom_range(1, IO_TO + 1), $urandom,
                ($urandom % 10) == 0);
    end
    idle_cycles(RD_LAT + 2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
